// File: rtl/sirv_gnrl_xchk_sched.sv
`default_nettype none
// sirv_gnrl_xchk_sched: round-robin scheduler that time-shares one X-checker across NCH buses
// and records per-channel sticky errors, the first failing ID and a saturating error count.
module sirv_gnrl_xchk_sched #(
  parameter int NCH      = 4,
  parameter int DW       = 32,
  parameter int IW       = 2,
  parameter int CW       = 8,
  parameter int ARM_CYC  = 16,
  parameter int HALT_ERR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [NCH-1:0]    i_mask,
  input  logic [NCH-1:0]    i_vld,
  input  logic [NCH*DW-1:0] i_dat,
  output logic [NCH-1:0]    o_gnt,
  output logic              o_chk_vld,
  output logic [DW-1:0]     o_chk_dat,
  output logic [IW-1:0]     o_chk_id,
  input  logic              i_chk_err,
  output logic [NCH-1:0]    o_err_sticky,
  output logic              o_err_any,
  output logic [IW-1:0]     o_err_first,
  output logic [CW-1:0]     o_err_cnt,
  output logic [1:0]        o_state
);

  localparam int AW = (ARM_CYC > 1) ? $clog2(ARM_CYC) : 1;
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ARM  = 2'b01,
    S_RUN  = 2'b10,
    S_HALT = 2'b11
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [AW-1:0]   arm_cnt;
  logic [NCH-1:0]  elig;
  logic [NCH-1:0]  gnt;
  logic [IW-1:0]   gnt_id;
  logic [DW-1:0]   gnt_dat;
  logic            found;
  logic            rec;
  logic            halt_go;
  logic            launch;

  function automatic int wrap(input int v);
    return (v >= NCH) ? v - NCH : v;
  endfunction

  // Search starts just above the last granted channel, so every eligible channel is reached
  // within NCH grants.
  always_comb begin
    elig    = i_vld & ~i_mask;
    gnt     = '0;
    gnt_id  = '0;
    gnt_dat = '0;
    found   = 1'b0;
    if (state == S_RUN) begin
      for (int i = 1; i <= NCH; i++) begin
        if (!found && elig[wrap(int'(ptr) + i)]) begin
          found   = 1'b1;
          gnt[wrap(int'(ptr) + i)] = 1'b1;
          gnt_id  = IW'(wrap(int'(ptr) + i));
          gnt_dat = i_dat[wrap(int'(ptr) + i)*DW +: DW];
        end
      end
    end
  end

  // Clear beats a same-cycle error; a halting error suppresses the sample granted alongside it.
  assign rec     = o_chk_vld & i_chk_err & (state == S_RUN) & ~i_clr;
  assign halt_go = rec & i_en & (HALT_ERR != 0);
  assign launch  = found & i_en & ~halt_go;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ptr          <= IW'(NCH - 1);
      arm_cnt      <= '0;
      o_chk_vld    <= 1'b0;
      o_chk_dat    <= '0;
      o_chk_id     <= '0;
      o_err_sticky <= '0;
      o_err_first  <= '0;
      o_err_cnt    <= '0;
    end else begin
      if (!i_en) begin
        state   <= S_IDLE;
        arm_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            state   <= S_ARM;
            arm_cnt <= '0;
          end
          S_ARM: begin
            if (arm_cnt == ARM_LAST) state <= S_RUN;
            else arm_cnt <= arm_cnt + 1'b1;
          end
          S_RUN:  if (halt_go) state <= S_HALT;
          S_HALT: if (i_clr) state <= S_RUN;
          default: state <= S_IDLE;
        endcase
      end

      if (found) ptr <= gnt_id;

      o_chk_vld <= launch;
      if (launch) begin
        o_chk_dat <= gnt_dat;
        o_chk_id  <= gnt_id;
      end

      if (i_clr) begin
        o_err_sticky <= '0;
        o_err_first  <= '0;
        o_err_cnt    <= '0;
      end else if (rec) begin
        o_err_sticky[o_chk_id] <= 1'b1;
        if (o_err_cnt != {CW{1'b1}}) o_err_cnt <= o_err_cnt + 1'b1;
        if (o_err_sticky == '0) o_err_first <= o_chk_id;
      end
    end
  end

  assign o_gnt     = gnt;
  assign o_err_any = |o_err_sticky;
  assign o_state   = state;

endmodule
`default_nettype wire

// File: tb/tb_sirv_gnrl_xchk_sched.sv
`default_nettype none
// Directed bench: dut_a uses defaults (halt on error); dut_b uses HALT_ERR=0, CW=2.
module tb_sirv_gnrl_xchk_sched;

  logic         clk = 1'b0;
  logic         rst, en, clr_a, clr_b, err_a, err_b;
  logic [3:0]   mask, vld;
  logic [127:0] dat;

  logic [3:0]  gnt_a, stk_a, gnt_b, stk_b;
  logic        cv_a, any_a, cv_b, any_b;
  logic [31:0] cd_a, cd_b;
  logic [1:0]  cid_a, first_a, st_a, cid_b, first_b, st_b, cnt_b;
  logic [7:0]  cnt_a;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sirv_gnrl_xchk_sched dut_a (
    .clk(clk), .rst(rst), .i_en(en), .i_clr(clr_a), .i_mask(mask), .i_vld(vld), .i_dat(dat),
    .o_gnt(gnt_a), .o_chk_vld(cv_a), .o_chk_dat(cd_a), .o_chk_id(cid_a), .i_chk_err(err_a),
    .o_err_sticky(stk_a), .o_err_any(any_a), .o_err_first(first_a), .o_err_cnt(cnt_a),
    .o_state(st_a)
  );

  sirv_gnrl_xchk_sched #(.CW(2), .HALT_ERR(0)) dut_b (
    .clk(clk), .rst(rst), .i_en(en), .i_clr(clr_b), .i_mask(mask), .i_vld(vld), .i_dat(dat),
    .o_gnt(gnt_b), .o_chk_vld(cv_b), .o_chk_dat(cd_b), .o_chk_id(cid_b), .i_chk_err(err_b),
    .o_err_sticky(stk_b), .o_err_any(any_b), .o_err_first(first_b), .o_err_cnt(cnt_b),
    .o_state(st_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1-2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr_a = 1'b0; clr_b = 1'b0; err_a = 1'b0; err_b = 1'b0;
    mask = 4'h0; vld = 4'h0;
    dat = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    tick(); tick();
    #1;
    chk("rst_state", st_a, 2'b00);
    chk("rst_gnt", gnt_a, 4'h0);
    chk("rst_chk_vld", cv_a, 1'b0);
    chk("rst_chk_dat", cd_a, 32'h0);
    chk("rst_sticky", stk_a, 4'h0);
    chk("rst_cnt", cnt_a, 8'h0);
    chk("rst_first", first_a, 2'd0);
    rst = 1'b0;
    tick();

    // t0: enable with all channels valid
    en = 1'b1; vld = 4'hF;
    #1;
    chk("t0_idle", st_a, 2'b00);
    for (int k = 1; k <= 16; k++) begin
      tick(); #1;
      chk("arm_state", st_a, 2'b01);
      chk("arm_gnt", gnt_a, 4'h0);
    end
    tick(); #1;                                       // t0+17
    chk("run_state", st_a, 2'b10);
    chk("rr_gnt0", gnt_a, 4'b0001);
    chk("pre_chk_vld", cv_a, 1'b0);
    tick(); #1;                                       // t0+18
    chk("lat_chk_vld", cv_a, 1'b1);
    chk("lat_chk_id", cid_a, 2'd0);
    chk("lat_chk_dat", cd_a, 32'hC0DE_0000);
    chk("rr_gnt1", gnt_a, 4'b0010);
    tick(); #1;
    chk("rr_gnt2", gnt_a, 4'b0100);
    chk("rr_id1", cid_a, 2'd1);
    tick(); #1;
    chk("rr_gnt3", gnt_a, 4'b1000);
    chk("rr_dat2", cd_a, 32'hC0DE_0002);
    tick(); #1;                                       // t0+21
    chk("rr_wrap", gnt_a, 4'b0001);

    tick(); mask = 4'b0100; #1;                       // t0+22
    chk("mask_gnt1", gnt_a, 4'b0010);
    tick(); #1;
    chk("mask_gnt3", gnt_a, 4'b1000);
    tick(); #1;
    chk("mask_gnt0", gnt_a, 4'b0001);
    tick(); mask = 4'h0; #1;                          // t0+25
    chk("unmask_gnt1", gnt_a, 4'b0010);
    chk("mask_id0", cid_a, 2'd0);
    tick(); #1;                                       // t0+26
    chk("pre_err_id", cid_a, 2'd1);
    tick(); #1;                                       // t0+27: in-flight id 2 flagged
    chk("err_id", cid_a, 2'd2);
    err_a = 1'b1;
    tick();                                           // t0+28
    err_a = 1'b0; err_b = 1'b1;
    #1;
    chk("err_sticky", stk_a, 4'b0100);
    chk("err_first", first_a, 2'd2);
    chk("err_cnt", cnt_a, 8'd1);
    chk("err_any", any_a, 1'b1);
    chk("halt_state", st_a, 2'b11);
    chk("halt_gnt", gnt_a, 4'h0);
    chk("halt_chk_vld", cv_a, 1'b0);
    chk("b_id3", cid_b, 2'd3);
    clr_a = 1'b1;
    tick();                                           // t0+29
    clr_a = 1'b0; err_b = 1'b0;
    #1;
    chk("clr_state", st_a, 2'b10);
    chk("clr_sticky", stk_a, 4'h0);
    chk("clr_cnt", cnt_a, 8'd0);
    chk("clr_any", any_a, 1'b0);
    chk("resume_gnt", gnt_a, 4'b0001);
    chk("b_first_err", stk_b, 4'b1000);
    tick(); #1;                                       // t0+30
    chk("b_id1", cid_b, 2'd1);
    err_b = 1'b1;
    tick(); #1;                                       // t0+31
    chk("b_sticky", stk_b, 4'b1010);
    chk("b_first", first_b, 2'd3);
    chk("b_cnt2", cnt_b, 2'd2);
    chk("b_no_halt", st_b, 2'b10);
    tick(); tick(); tick(); #1;                       // t0+34
    chk("b_sat_cnt", cnt_b, 2'd3);
    chk("b_sat_sticky", stk_b, 4'b1111);
    clr_b = 1'b1;                                     // err_b still 1: clear wins
    tick();                                           // t0+35
    clr_b = 1'b0;
    #1;
    chk("b_clr_sticky", stk_b, 4'h0);
    chk("b_clr_cnt", cnt_b, 2'd0);
    chk("b_clr_first", first_b, 2'd0);
    chk("b_clr_any", any_b, 1'b0);
    chk("b_id2", cid_b, 2'd2);
    en = 1'b0;                                        // error on id 2 while disabling
    tick();                                           // t0+36
    err_b = 1'b0;
    #1;
    chk("dis_state_a", st_a, 2'b00);
    chk("dis_chk_vld_a", cv_a, 1'b0);
    chk("dis_gnt_a", gnt_a, 4'h0);
    chk("dis_state_b", st_b, 2'b00);
    chk("dis_chk_vld_b", cv_b, 1'b0);
    chk("dis_sticky_b", stk_b, 4'b0100);
    chk("dis_cnt_b", cnt_b, 2'd1);
    chk("dis_first_b", first_b, 2'd2);
    en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick(); #1;
      chk("rearm_state", st_a, 2'b01);
    end
    tick(); #1;
    chk("rearm_run", st_a, 2'b10);
    chk("rearm_sticky_b", stk_b, 4'b0100);
    tick(); tick(); #1;
    chk("rerun_chk_vld", cv_a, 1'b1);
    rst = 1'b1;
    tick(); #1;
    chk("mrst_state", st_a, 2'b00);
    chk("mrst_gnt", gnt_a, 4'h0);
    chk("mrst_chk_vld", cv_a, 1'b0);
    chk("mrst_chk_dat", cd_a, 32'h0);
    chk("mrst_chk_id", cid_a, 2'd0);
    chk("mrst_sticky_b", stk_b, 4'h0);
    chk("mrst_cnt_b", cnt_b, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
